// File: rtl/ball_game_pkg.sv
// rtl/ball_game_pkg.sv - shared types and helpers for the ball game sequencer
// Purpose: game state encoding and a signed clamp used by the per-axis stepper.
// Ports: none (package).
package ball_game_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_PLAY, ST_HIT, ST_OVER} game_state_t;

  // Wide enough to hold any signed intermediate coordinate of either axis.
  localparam int COORD_W = 16;

  function automatic logic signed [COORD_W-1:0] clamp_coord(
    input logic signed [COORD_W-1:0] value,
    input logic signed [COORD_W-1:0] lo,
    input logic signed [COORD_W-1:0] hi
  );
    if (value < lo) begin
      return lo;
    end else if (value > hi) begin
      return hi;
    end else begin
      return value;
    end
  endfunction

endpackage

// File: rtl/ball_axis_step.sv
// rtl/ball_axis_step.sv - combinational one-axis step with keep-in clamping
// Purpose: next position for one axis from a pair of opposing direction keys.
// Ports: pos (current centre), key_inc (+STEP), key_dec (-STEP), next_pos (clamped result).
module ball_axis_step
  import ball_game_pkg::*;
#(
  parameter int DIM    = 800,
  parameter int RADIUS = 20,
  parameter int STEP   = 2,
  parameter int W      = $clog2(DIM)
) (
  input  logic [W-1:0] pos,
  input  logic         key_inc,
  input  logic         key_dec,
  output logic [W-1:0] next_pos
);

  // Two spare bits so a step below zero or past the top stays representable.
  localparam int SW = W + 2;

  logic signed [SW-1:0]      pos_s;
  logic signed [SW-1:0]      delta;
  logic signed [SW-1:0]      sum;
  logic signed [COORD_W-1:0] sum_ext;
  logic signed [COORD_W-1:0] clamped;

  always_comb begin
    pos_s = $signed({2'b00, pos});
    delta = '0;
    // Both keys (or neither) cancel out.
    if (key_inc && !key_dec) begin
      delta = SW'(STEP);
    end else if (key_dec && !key_inc) begin
      delta = -SW'(STEP);
    end
    sum      = pos_s + delta;
    sum_ext  = {{(COORD_W - SW){sum[SW-1]}}, sum};
    clamped  = clamp_coord(sum_ext, COORD_W'(RADIUS), COORD_W'(DIM - 1 - RADIUS));
    next_pos = W'(clamped);
  end

endmodule

// File: rtl/ball_game_ctrl.sv
// rtl/ball_game_ctrl.sv - per-frame ball position and hit/lives/game-over sequencer
// Purpose: moves the ball once per frame at start of vertical blanking, samples the
//   safe map at the ball centre during the active frame, and runs the game FSM.
// Ports: i_clk, i_rst_n (async active-low); VGA i_h_coord/i_v_coord/i_disp_enbl;
//   i_is_safe; debounced i_key_up/down/left/right; i_start; outputs o_ball_x/y,
//   o_lives, o_hit (pulse), o_game_over, o_frame_tick (pulse).
module ball_game_ctrl
  import ball_game_pkg::*;
#(
  parameter int SCREEN_WIDTH  = 800,
  parameter int SCREEN_HEIGHT = 600,
  parameter int BALL_RADIUS   = 20,
  parameter int STEP          = 2,
  parameter int START_X       = 400,
  parameter int START_Y       = 300,
  parameter int LIVES         = 3,
  parameter int HIT_FRAMES    = 60
) (
  input  logic                             i_clk,
  input  logic                             i_rst_n,
  input  logic [10:0]                      i_h_coord,
  input  logic [9:0]                       i_v_coord,
  input  logic                             i_disp_enbl,
  input  logic                             i_is_safe,
  input  logic                             i_key_up,
  input  logic                             i_key_down,
  input  logic                             i_key_left,
  input  logic                             i_key_right,
  input  logic                             i_start,
  output logic [$clog2(SCREEN_WIDTH)-1:0]  o_ball_x,
  output logic [$clog2(SCREEN_HEIGHT)-1:0] o_ball_y,
  output logic [2:0]                       o_lives,
  output logic                             o_hit,
  output logic                             o_game_over,
  output logic                             o_frame_tick
);

  localparam int XW    = $clog2(SCREEN_WIDTH);
  localparam int YW    = $clog2(SCREEN_HEIGHT);
  localparam int CNT_W = $clog2(HIT_FRAMES + 1);

  game_state_t      state_q, state_d;
  logic [9:0]       v_prev;
  logic             frame_end;
  logic             centre_seen, centre_safe;
  logic [CNT_W-1:0] hit_cnt_q, hit_cnt_d;
  logic [XW-1:0]    ball_x_d, next_x;
  logic [YW-1:0]    ball_y_d, next_y;
  logic [2:0]       lives_d;
  logic             hit_d;

  // First line of vertical blanking, seen once per frame.
  assign frame_end   = (i_v_coord == 10'(SCREEN_HEIGHT)) && (v_prev != 10'(SCREEN_HEIGHT));
  assign o_game_over = (state_q == ST_OVER);

  ball_axis_step #(.DIM(SCREEN_WIDTH), .RADIUS(BALL_RADIUS), .STEP(STEP)) u_step_x (
    .pos      (o_ball_x),
    .key_inc  (i_key_right),
    .key_dec  (i_key_left),
    .next_pos (next_x)
  );

  ball_axis_step #(.DIM(SCREEN_HEIGHT), .RADIUS(BALL_RADIUS), .STEP(STEP)) u_step_y (
    .pos      (o_ball_y),
    .key_inc  (i_key_down),
    .key_dec  (i_key_up),
    .next_pos (next_y)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= ST_IDLE;
      o_ball_x     <= XW'(START_X);
      o_ball_y     <= YW'(START_Y);
      o_lives      <= 3'(LIVES);
      o_hit        <= 1'b0;
      o_frame_tick <= 1'b0;
      hit_cnt_q    <= '0;
      v_prev       <= '0;
      centre_seen  <= 1'b0;
      centre_safe  <= 1'b0;
    end else begin
      state_q      <= state_d;
      o_ball_x     <= ball_x_d;
      o_ball_y     <= ball_y_d;
      o_lives      <= lives_d;
      o_hit        <= hit_d;
      o_frame_tick <= frame_end;
      hit_cnt_q    <= hit_cnt_d;
      v_prev       <= i_v_coord;
      // Centre sampling happens in the active area, so it never collides with frame_end.
      if (frame_end) begin
        centre_seen <= 1'b0;
        centre_safe <= 1'b0;
      end else if (i_disp_enbl && (i_h_coord == 11'(o_ball_x)) && (i_v_coord == 10'(o_ball_y))) begin
        centre_seen <= 1'b1;
        centre_safe <= i_is_safe;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    ball_x_d  = o_ball_x;
    ball_y_d  = o_ball_y;
    lives_d   = o_lives;
    hit_cnt_d = hit_cnt_q;
    hit_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        ball_x_d = XW'(START_X);
        ball_y_d = YW'(START_Y);
        if (i_start) state_d = ST_PLAY;
      end
      ST_PLAY: begin
        if (frame_end) begin
          if (centre_seen && !centre_safe) begin
            state_d   = ST_HIT;
            hit_d     = 1'b1;
            lives_d   = o_lives - 3'd1;
            ball_x_d  = XW'(START_X);
            ball_y_d  = YW'(START_Y);
            hit_cnt_d = CNT_W'(HIT_FRAMES - 1);
          end else begin
            ball_x_d = next_x;
            ball_y_d = next_y;
          end
        end
      end
      ST_HIT: begin
        if (frame_end) begin
          if (hit_cnt_q != '0) begin
            hit_cnt_d = hit_cnt_q - CNT_W'(1);
          end else if (o_lives == 3'd0) begin
            state_d = ST_OVER;
          end else begin
            state_d = ST_PLAY;
          end
        end
      end
      ST_OVER: begin
        if (i_start) begin
          lives_d  = 3'(LIVES);
          ball_x_d = XW'(START_X);
          ball_y_d = YW'(START_Y);
          state_d  = ST_PLAY;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_ball_game_ctrl.sv
// tb/tb_ball_game_ctrl.sv - directed self-checking bench for ball_game_ctrl
module tb_ball_game_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [10:0] h_coord;
  logic [9:0]  v_coord;
  logic        disp_enbl, is_safe;
  logic        key_up, key_down, key_left, key_right, start;
  logic [9:0]  ball_x, ball_y;
  logic [2:0]  lives;
  logic        hit, game_over, frame_tick;

  int checks   = 0;
  int failures = 0;
  int tick_cnt = 0;
  int exp_x    = 400;
  int exp_y    = 300;
  int bad      = 0;

  always #5 clk = ~clk;

  always @(negedge clk) if (frame_tick === 1'b1) tick_cnt++;

  ball_game_ctrl dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_h_coord   (h_coord),
    .i_v_coord   (v_coord),
    .i_disp_enbl (disp_enbl),
    .i_is_safe   (is_safe),
    .i_key_up    (key_up),
    .i_key_down  (key_down),
    .i_key_left  (key_left),
    .i_key_right (key_right),
    .i_start     (start),
    .o_ball_x    (ball_x),
    .o_ball_y    (ball_y),
    .o_lives     (lives),
    .o_hit       (hit),
    .o_game_over (game_over),
    .o_frame_tick(frame_tick)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int clampi(input int v, input int lo, input int hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  // Compressed frame: one active pixel at the expected ball centre, then the
  // first blanking line. Returns just after the frame_end edge has taken effect.
  task automatic frame(input logic safe);
    @(negedge clk);
    disp_enbl = 1'b1; h_coord = 11'(exp_x); v_coord = 10'(exp_y); is_safe = safe;
    check("active_x", 32'(ball_x), 32'(exp_x));
    check("active_y", 32'(ball_y), 32'(exp_y));
    check("hit_idle", 32'(hit), 32'd0);
    @(negedge clk);
    disp_enbl = 1'b0; h_coord = '0; v_coord = 10'd600; is_safe = 1'b1;
    @(negedge clk);
    v_coord = 10'd0;
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; h_coord = '0; v_coord = '0; disp_enbl = 1'b0; is_safe = 1'b1;
    key_up = 0; key_down = 0; key_left = 0; key_right = 0; start = 0;
    repeat (3) @(negedge clk);
    check("rst_x", 32'(ball_x), 32'd400);
    check("rst_y", 32'(ball_y), 32'd300);
    check("rst_lives", 32'(lives), 32'd3);
    check("rst_hit", 32'(hit), 32'd0);
    check("rst_over", 32'(game_over), 32'd0);
    check("rst_tick", 32'(frame_tick), 32'd0);
    rst_n = 1'b1;

    // IDLE ignores keys until start.
    key_right = 1; frame(1); frame(1);
    check("idle_hold_x", 32'(ball_x), 32'd400);
    key_right = 0;

    pulse_start();
    tick_cnt = 0;
    key_right = 1;
    repeat (3) begin frame(1); exp_x = clampi(exp_x + 2, 20, 779); end
    check("right3_x", 32'(ball_x), 32'd406);
    check("right3_y", 32'(ball_y), 32'd300);
    check("right3_lives", 32'(lives), 32'd3);
    @(negedge clk);
    check("tick_count", 32'(tick_cnt), 32'd3);

    key_right = 0; key_left = 1;
    repeat (3) begin frame(1); exp_x = clampi(exp_x - 2, 20, 779); end
    check("left3_x", 32'(ball_x), 32'd400);
    key_right = 1;
    repeat (5) frame(1);
    check("both_x", 32'(ball_x), 32'd400);
    key_right = 0;
    repeat (300) begin
      frame(1); exp_x = clampi(exp_x - 2, 20, 779);
      if (ball_x < 10'd20 || ball_x > 10'd400) bad = 1;
    end
    check("left_range", 32'(bad), 32'd0);
    check("left_clamp_x", 32'(ball_x), 32'd20);
    key_left = 0; key_down = 1;
    repeat (150) begin frame(1); exp_y = clampi(exp_y + 2, 20, 579); end
    check("down_clamp_y", 32'(ball_y), 32'd579);
    key_down = 0;

    // First hit: respawn, lose a life, freeze for 60 frames.
    frame(0); exp_x = 400; exp_y = 300;
    check("hit1_pulse", 32'(hit), 32'd1);
    check("hit1_lives", 32'(lives), 32'd2);
    check("hit1_x", 32'(ball_x), 32'd400);
    check("hit1_y", 32'(ball_y), 32'd300);
    key_right = 1;
    repeat (60) frame(1);
    check("hit_frozen_x", 32'(ball_x), 32'd400);
    frame(1); exp_x = 402;
    check("replay_x", 32'(ball_x), 32'd402);
    key_right = 0;

    frame(0); exp_x = 400;
    check("hit2_lives", 32'(lives), 32'd1);
    repeat (60) frame(1);
    check("hit2_not_over", 32'(game_over), 32'd0);
    frame(0);
    check("hit3_lives", 32'(lives), 32'd0);
    repeat (59) frame(1);
    check("over_not_yet", 32'(game_over), 32'd0);
    frame(1);
    check("over_flag", 32'(game_over), 32'd1);
    check("over_lives", 32'(lives), 32'd0);
    pulse_start();
    check("restart_lives", 32'(lives), 32'd3);
    check("restart_over", 32'(game_over), 32'd0);
    key_right = 1; frame(1); exp_x = 402;
    check("restart_move", 32'(ball_x), 32'd402);
    key_right = 0;

    // Reset while frozen after a hit (hit counter at 30).
    frame(0); exp_x = 400;
    check("hit4_lives", 32'(lives), 32'd2);
    repeat (29) frame(1);
    @(negedge clk);
    disp_enbl = 1'b1; h_coord = 11'd400; v_coord = 10'd300;
    #2 rst_n = 1'b0;
    #1;
    check("async_lives", 32'(lives), 32'd3);
    check("async_x", 32'(ball_x), 32'd400);
    check("async_hit", 32'(hit), 32'd0);
    check("async_over", 32'(game_over), 32'd0);
    @(negedge clk);
    rst_n = 1'b1; disp_enbl = 1'b0; v_coord = 10'd0;
    key_right = 1;
    frame(1); frame(1);
    check("post_rst_idle_x", 32'(ball_x), 32'd400);
    pulse_start();
    frame(1); exp_x = 402;
    check("post_rst_move_x", 32'(ball_x), 32'd402);
    key_right = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ball_game_ctrl.md
Name: ball_game_ctrl

Overview:
- Per-frame game sequencer that owns the ball position fed to the pixel renderer (renderer inputs i_screen_ball_x/y).
- Advances the position once per frame during vertical blanking from debounced direction keys, clamped to the screen.
- Samples the safe-map result at the ball centre during the active frame and runs the hit / lives / game-over state machine.
- Sits between the VGA timing generator, the keypad debouncer, the safe-map lookup and the renderer.

Parameters:
- SCREEN_WIDTH, 800, visible width in pixels
- SCREEN_HEIGHT, 600, visible height in lines
- BALL_RADIUS, 20, ball radius in pixels; keep-in margin for clamping
- STEP, 2, pixels moved per frame per axis
- START_X, 400, reset/respawn x
- START_Y, 300, reset/respawn y
- LIVES, 3, lives per game (1..7)
- HIT_FRAMES, 60, frames the ball stays frozen after a hit

Ports:
- i_clk  in  1  system/pixel clock
- i_rst_n  in  1  asynchronous active-low reset
- i_h_coord  in  11  VGA horizontal pixel coordinate
- i_v_coord  in  10  VGA vertical line coordinate
- i_disp_enbl  in  1  VGA display enable
- i_is_safe  in  1  safe-map result for the current (i_h_coord, i_v_coord), same cycle
- i_key_up, i_key_down, i_key_left, i_key_right  in  1 each  debounced level keys
- i_start  in  1  start/restart request (level)
- o_ball_x  out  $clog2(SCREEN_WIDTH)  committed ball centre x
- o_ball_y  out  $clog2(SCREEN_HEIGHT)  committed ball centre y
- o_lives  out  3  remaining lives
- o_hit  out  1  one-cycle pulse on the frame where a hit is registered
- o_game_over  out  1  high in OVER state
- o_frame_tick  out  1  one-cycle pulse at start of vertical blanking

Behaviour:
- Reset (async, i_rst_n=0), all outputs: o_ball_x=START_X, o_ball_y=START_Y, o_lives=LIVES, o_hit=0, o_game_over=0, o_frame_tick=0; state=IDLE; centre flags cleared; hit counter=0.
- Frame tick: register v_prev. frame_end is combinational, high when i_v_coord==SCREEN_HEIGHT and v_prev!=SCREEN_HEIGHT. o_frame_tick is frame_end registered, giving exactly one pulse per frame. All position/state updates take effect on the clock edge where frame_end is high, so outputs are stable for the whole following active frame.
- Centre sample: when i_disp_enbl is high and i_h_coord==o_ball_x and i_v_coord==o_ball_y, set centre_seen=1 and centre_safe=i_is_safe. Both flags clear on frame_end. Sampling and frame_end cannot coincide (active vs blanking).
- Axis step, per axis: dir = +1 for right/down only, -1 for left/up only, 0 for none or both. Compute next = pos + dir*STEP in (width+2)-bit signed. Clamp to [BALL_RADIUS, SCREEN_DIM-1-BALL_RADIUS]. No wrap-around.
- FSM states: IDLE, PLAY, HIT, OVER.
  - IDLE: ball held at START. i_start=1 → PLAY (immediate, not frame-aligned).
  - PLAY, on frame_end: if centre_seen && !centre_safe → HIT, o_hit=1, o_lives-=1, ball←START, hit_cnt←HIT_FRAMES-1. Otherwise apply the axis step to both axes. i_start is ignored in PLAY.
  - HIT, on frame_end: if hit_cnt!=0, decrement it. If hit_cnt==0: go to OVER if o_lives==0, else PLAY. Keys are ignored; the ball stays at START.
  - OVER: o_game_over=1. i_start=1 → o_lives←LIVES, ball←START, → PLAY.
- If centre_seen==0 at frame_end (ball centre off-screen, not possible after clamping), no hit is registered.
- Reset mid-frame or mid-HIT: immediate return to reset values; the next frame is treated as the first.

Decomposition:
- Package ball_game_pkg holds:
  - typedef enum logic [1:0] {ST_IDLE, ST_PLAY, ST_HIT, ST_OVER} game_state_t
  - function clamp_coord (signed value, lo, hi)
- One sub-module, ball_axis_step: combinational dir/clamp for one axis, parameterised by DIM, RADIUS, STEP, instantiated twice (x and y).
- The FSM, frame-tick logic and centre sampler stay in ball_game_ctrl.

Test Plan:
- Reset then i_start=1 for 1 cycle, all pixels safe, i_key_right held for 3 frames → o_ball_x=406, o_ball_y=300, o_frame_tick pulses exactly 3 times, o_lives=3.
- Start at 400, left+right both held for 5 frames → o_ball_x stays 400. i_key_left held for 300 frames → o_ball_x clamps at 20, never below and never wrapping.
- i_key_down held long enough → o_ball_y saturates at 579 (600-1-20). Position changes only on the cycle after frame_end, never during an active line.
- i_is_safe=0 at pixel (400,300) in one frame → o_hit pulse at that frame_end, o_lives=2, ball at (400,300). Keys are ignored for 60 frames, then state returns to PLAY.
- Three unsafe frames with HIT_FRAMES=2 → o_lives 3→2→1→0, then o_game_over=1. i_start → o_lives=3, o_game_over=0, PLAY.
- Assert i_rst_n=0 mid-HIT at hit_cnt=30 → outputs return to reset values asynchronously, state IDLE. i_start is required before any movement.
